debug_mem_responder: RTL and testbench

//  Memory-side responder for the host/debug memory port (Tb_MEMAddr/Tb_MEMData/Tb_MEMWE/TBorNot).

---
 rtl/debug_mem_responder_pkg.sv | 16 +
 rtl/debug_mem_responder_ram.sv | 32 +++
 rtl/debug_mem_responder.sv | 149 ++++++++++++++
 tb/tb_debug_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/debug_mem_responder_pkg.sv
// Shared definitions for the host/debug memory responder.
//   DMR_ADDR_W / DMR_DATA_W : default RAM geometry (256 x 16)
//   dmr_state_e             : arbiter states
package debug_mem_responder_pkg;

    localparam int unsigned DMR_ADDR_W = 8;
    localparam int unsigned DMR_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_CPU,
        ST_HOST,
        ST_REPLAY,
        ST_CLEAR
    } dmr_state_e;

endpackage

// File: rtl/debug_mem_responder_ram.sv
// Single-port, read-first RAM with a registered read port (block RAM style).
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, old contents on a write cycle
module dbg_ram_sp #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/debug_mem_responder.sv
// Memory-side responder for the host/debug port of the multicycle RISC computer.
// Owns the unified instruction/data RAM and arbitrates it between host and CPU
// (host wins), keeps the host read-back register and stalls the CPU around
// host accesses.
//   clk, Rst                              : clock, synchronous active-high reset
//   TBorNot, Tb_MEMAddr/Data/WE           : host request, address, data, write enable
//   Tb_Busy                               : clear sweep running, host ignored
//   Tb_RdValid, OutMEM                    : host read pulse and held read data
//   Tb_WrCount                            : accepted host writes since reset (wraps)
//   MEMAddr, MEMWData, MEMWE              : CPU port
//   MEMRData, CPU_Stall                   : CPU read data and stall request
module debug_mem_responder
    import debug_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W         = DMR_ADDR_W,
    parameter int unsigned DATA_W         = DMR_DATA_W,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              TBorNot,
    input  logic [ADDR_W-1:0] Tb_MEMAddr,
    input  logic [DATA_W-1:0] Tb_MEMData,
    input  logic              Tb_MEMWE,
    output logic              Tb_Busy,
    output logic              Tb_RdValid,
    output logic [DATA_W-1:0] OutMEM,
    output logic [ADDR_W-1:0] Tb_WrCount,
    input  logic [ADDR_W-1:0] MEMAddr,
    input  logic [DATA_W-1:0] MEMWData,
    input  logic              MEMWE,
    output logic [DATA_W-1:0] MEMRData,
    output logic              CPU_Stall
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    dmr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [DATA_W-1:0] outmem_q;
    logic              rdvalid_q;
    logic              cpu_own_q;
    logic [DATA_W-1:0] memr_q;

    logic              host_sel;
    logic              host_wr;
    logic              host_rd;
    logic              cpu_own;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Host requests are ignored while the clear sweep owns the RAM.
    assign host_sel = TBorNot && (state_q != ST_CLEAR);
    assign host_wr  = host_sel && Tb_MEMWE;
    assign host_rd  = host_sel && !Tb_MEMWE;
    assign cpu_own  = !TBorNot && (state_q != ST_CLEAR);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = MEMAddr;
        ram_wdata = MEMWData;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            ram_wdata = '0;
        end else if (TBorNot) begin
            ram_we    = Tb_MEMWE;
            ram_addr  = Tb_MEMAddr;
            ram_wdata = Tb_MEMData;
        end else begin
            ram_we    = MEMWE;
        end
        // A reset cycle never modifies the RAM, so an in-flight access is dropped.
        if (Rst) begin
            ram_we = 1'b0;
        end
    end

    dbg_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        Tb_Busy   = 1'b0;
        CPU_Stall = TBorNot;
        case (state_q)
            ST_CPU: begin
                if (TBorNot) state_d = ST_HOST;
            end
            ST_HOST: begin
                state_d = TBorNot ? ST_HOST : ST_REPLAY;
            end
            ST_REPLAY: begin
                CPU_Stall = 1'b1;
                state_d   = TBorNot ? ST_HOST : ST_CPU;
            end
            ST_CLEAR: begin
                Tb_Busy   = 1'b1;
                CPU_Stall = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_ONE;
                if (clr_cnt_q == ADDR_LAST) state_d = ST_CPU;
            end
            default: state_d = ST_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_CPU;
            clr_cnt_q <= '0;
            wr_cnt_q  <= '0;
            outmem_q  <= '0;
            rdvalid_q <= 1'b0;
            cpu_own_q <= 1'b0;
            memr_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (host_wr) wr_cnt_q <= wr_cnt_q + ADDR_ONE;
            rdvalid_q <= host_rd;
            cpu_own_q <= cpu_own;
            // Latch the RAM output one cycle after it appears so the
            // visible value stays put once the RAM moves on.
            if (rdvalid_q) outmem_q <= ram_rdata;
            if (cpu_own_q) memr_q   <= ram_rdata;
        end
    end

    // The RAM output register is the read register; the hold registers
    // take over on cycles where the RAM served someone else.
    assign OutMEM     = rdvalid_q ? ram_rdata : outmem_q;
    assign MEMRData   = cpu_own_q ? ram_rdata : memr_q;
    assign Tb_RdValid = rdvalid_q;
    assign Tb_WrCount = wr_cnt_q;

endmodule

// File: tb/tb_debug_mem_responder.sv
module tb_debug_mem_responder;

    logic        clk = 1'b0;
    logic        rst0, rst1, tb0, tb1;
    logic [7:0]  taddr, maddr;
    logic [15:0] tdata, mwdata;
    logic        twe, mwe;

    logic        busy0, rdv0, stall0, busy1, rdv1, stall1;
    logic [15:0] outmem0, mrdata0, outmem1, mrdata1;
    logic [7:0]  wrcnt0, wrcnt1;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned n;

    always #5 clk = ~clk;

    debug_mem_responder #(.ADDR_W(8), .DATA_W(16), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .Rst(rst0), .TBorNot(tb0), .Tb_MEMAddr(taddr), .Tb_MEMData(tdata),
        .Tb_MEMWE(twe), .Tb_Busy(busy0), .Tb_RdValid(rdv0), .OutMEM(outmem0),
        .Tb_WrCount(wrcnt0), .MEMAddr(maddr), .MEMWData(mwdata), .MEMWE(mwe),
        .MEMRData(mrdata0), .CPU_Stall(stall0)
    );

    debug_mem_responder #(.ADDR_W(8), .DATA_W(16), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .Rst(rst1), .TBorNot(tb1), .Tb_MEMAddr(taddr), .Tb_MEMData(tdata),
        .Tb_MEMWE(twe), .Tb_Busy(busy1), .Tb_RdValid(rdv1), .OutMEM(outmem1),
        .Tb_WrCount(wrcnt1), .MEMAddr(maddr), .MEMWData(mwdata), .MEMWE(mwe),
        .MEMRData(mrdata1), .CPU_Stall(stall1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tb(input bit sel, input logic v);
        if (sel) tb1 = v;
        else     tb0 = v;
    endtask

    task automatic host_wr(input bit sel, input logic [7:0] a, input logic [15:0] d);
        set_tb(sel, 1'b1);
        taddr = a;
        tdata = d;
        twe   = 1'b1;
        tick();
        set_tb(sel, 1'b0);
        twe   = 1'b0;
    endtask

    task automatic host_rd(input bit sel, input logic [7:0] a);
        set_tb(sel, 1'b1);
        taddr = a;
        twe   = 1'b0;
        tick();
        set_tb(sel, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; tb0 = 1'b0; tb1 = 1'b0;
        taddr = '0; tdata = '0; twe = 1'b0;
        maddr = '0; mwdata = '0; mwe = 1'b0;
        tick(); tick();
        rst0 = 1'b0;

        // Reset state
        chk("rst_outmem", outmem0, 16'h0000);
        chk("rst_rdvalid", rdv0, 1'b0);
        chk("rst_wrcount", wrcnt0, 8'd0);
        chk("rst_memrdata", mrdata0, 16'h0000);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_stall", stall0, 1'b0);
        chk("rst_busy_clr", busy1, 1'b1);

        // 1: two host writes, then a host read
        host_wr(0, 8'h80, 16'h0064);
        host_wr(0, 8'h81, 16'h0001);
        chk("t1_wrcount", wrcnt0, 8'd2);
        host_rd(0, 8'h80);
        chk("t1_rdvalid", rdv0, 1'b1);
        chk("t1_outmem", outmem0, 16'h0064);
        tick();
        chk("t1_rdvalid_drop", rdv0, 1'b0);
        chk("t1_outmem_hold", outmem0, 16'h0064);

        // 2: CPU streaming reads of 0x81, host write in the middle
        maddr = 8'h81;
        tick(); tick(); tick();
        chk("t2_cpu_before", mrdata0, 16'h0001);
        tb0 = 1'b1; taddr = 8'h81; tdata = 16'hAAAA; twe = 1'b1;
        #1 chk("t2_stall_host", stall0, 1'b1);
        tick();
        tb0 = 1'b0; twe = 1'b0;
        tick();
        #1 chk("t2_stall_replay", stall0, 1'b1);
        tick();
        chk("t2_stall_done", stall0, 1'b0);
        chk("t2_cpu_after", mrdata0, 16'hAAAA);

        // 3: CPU and host write the same address on the same edge
        tick();
        maddr = 8'h90; mwdata = 16'h0065; mwe = 1'b1;
        tb0 = 1'b1; taddr = 8'h90; tdata = 16'h7777; twe = 1'b1;
        #1 chk("t3_stall", stall0, 1'b1);
        tick();
        mwe = 1'b0; tb0 = 1'b0; twe = 1'b0; maddr = 8'h00;
        host_rd(0, 8'h90);
        chk("t3_host_wins", outmem0, 16'h7777);

        // 4: write then read back; read-first on a same-cycle write
        host_wr(0, 8'h85, 16'h0050);
        host_rd(0, 8'h85);
        chk("t4_wr_then_rd", outmem0, 16'h0050);
        host_wr(0, 8'h86, 16'h1111);
        tick(); tick(); tick();
        maddr = 8'h86; mwdata = 16'h2222; mwe = 1'b1;
        tick();
        mwe = 1'b0;
        chk("t4_read_first_old", mrdata0, 16'h1111);
        tick();
        chk("t4_read_new", mrdata0, 16'h2222);
        host_rd(0, 8'h86);
        chk("t4_host_rd_new", outmem0, 16'h2222);
        maddr = 8'h00;

        // 6: write-count wrap and reset mid-stream
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        chk("t6_rst_wrcount", wrcnt0, 8'd0);
        chk("t6_rst_outmem", outmem0, 16'h0000);
        tb0 = 1'b1; twe = 1'b1;
        for (int i = 0; i < 257; i++) begin
            taddr = 8'(i);
            tdata = 16'(i);
            tick();
        end
        chk("t6_wrap", wrcnt0, 8'd1);
        taddr = 8'h40; tdata = 16'hBEEF;
        tick();
        chk("t6_count2", wrcnt0, 8'd2);
        rst0 = 1'b1; tdata = 16'hDEAD;
        tick();
        rst0 = 1'b0; tb0 = 1'b0; twe = 1'b0;
        chk("t6_rst_zero", wrcnt0, 8'd0);
        host_rd(0, 8'h40);
        chk("t6_rst_drops_wr", outmem0, 16'hBEEF);
        host_rd(0, 8'h00);
        chk("t6_addr0_last", outmem0, 16'h0100);
        host_rd(0, 8'h05);
        chk("t6_addr5", outmem0, 16'h0005);

        // 5: clear-on-reset instance
        rst1 = 1'b0;
        n = 0;
        while (busy1 && n < 400) begin tick(); n++; end
        chk("t5_first_sweep", n, 256);
        host_wr(1, 8'hA3, 16'hFFFF);
        host_rd(1, 8'hA3);
        chk("t5_preload", outmem1, 16'hFFFF);
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        n = 0;
        chk("t5_busy", busy1, 1'b1);
        tick(); tick(); n = 2;
        tb1 = 1'b1; taddr = 8'h01; tdata = 16'h1234; twe = 1'b1;
        #1 chk("t5_stall", stall1, 1'b1);
        tick(); n++;
        twe = 1'b0; taddr = 8'hA3;
        chk("t5_no_count", wrcnt1, 8'd0);
        tick(); n++;
        tb1 = 1'b0;
        chk("t5_no_rdvalid", rdv1, 1'b0);
        while (busy1 && n < 400) begin tick(); n++; end
        chk("t5_sweep_len", n, 256);
        host_rd(1, 8'hA3);
        chk("t5_cleared", outmem1, 16'h0000);
        host_rd(1, 8'h01);
        chk("t5_wr_ignored", outmem1, 16'h0000);
        chk("t5_wrcount", wrcnt1, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
